// File: rtl/appr_mac_accum.sv
// appr_mac_accum: packet accumulator behind the approximate Booth multiplier.
// Sums the signed products of one packet (terminated by prod_last) into a wide
// signed accumulator. It then presents the sum, the term count and a sticky
// overflow flag under a valid/ready handshake.
// Build option: define SATURATE_EN to clamp the accumulator on signed overflow
// instead of wrapping.
//
// state | meaning
// IDLE  | waiting for the first term of a packet
// RUN   | packet in progress, accumulating terms
// DONE  | result presented on acc_*, waiting for acc_ready
module appr_mac_accum #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_last,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc,
    output logic [CNT_W-1:0]  acc_cnt,
    output logic              acc_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum;
    logic               add_ovf;
    logic [ACC_W-1:0]   sat_val;

    assign prod_ready = !rst && (state_q != S_DONE);
    assign accept     = prod_valid && prod_ready;
    assign acc_valid  = (state_q == S_DONE);
    assign acc        = acc_q;
    assign acc_cnt    = cnt_q;
    assign acc_ovf    = ovf_q;

    // Sign-extend the product, then form the running sum and its overflow.
    assign prod_ext = ACC_W'($signed(prod));
    assign sum      = acc_q + prod_ext;
    assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);
    // Clamp target follows the sign of the addend.
    assign sat_val  = prod_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};

    // State, accumulator, counter and overflow registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update; everything holds unless a term is accepted.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = prod_ext;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = prod_last ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
`ifdef SATURATE_EN
                    acc_d = add_ovf ? sat_val : sum;
`else
                    acc_d = sum;
`endif
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    ovf_d   = ovf_q | add_ovf;
                    state_d = prod_last ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                if (acc_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_appr_mac_accum.sv
// Directed bench for appr_mac_accum: default 40-bit instance plus a 34-bit,
// 3-bit-counter instance for the overflow and count-saturation cases.
module tb_appr_mac_accum;

    logic        clk;
    logic        rst;
    logic        prod_valid;
    logic        prod_ready;
    logic [31:0] prod;
    logic        prod_last;
    logic        acc_valid;
    logic        acc_ready;
    logic [39:0] acc;
    logic [15:0] acc_cnt;
    logic        acc_ovf;

    logic        prod_valid34;
    logic        prod_ready34;
    logic [31:0] prod34;
    logic        prod_last34;
    logic        acc_valid34;
    logic        acc_ready34;
    logic [33:0] acc34;
    logic [2:0]  acc_cnt34;
    logic        acc_ovf34;

    int n_checks = 0;
    int n_fails  = 0;

    appr_mac_accum dut (
        .clk        (clk),
        .rst        (rst),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod       (prod),
        .prod_last  (prod_last),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc        (acc),
        .acc_cnt    (acc_cnt),
        .acc_ovf    (acc_ovf)
    );

    appr_mac_accum #(.PROD_W(32), .ACC_W(34), .CNT_W(3)) dut34 (
        .clk        (clk),
        .rst        (rst),
        .prod_valid (prod_valid34),
        .prod_ready (prod_ready34),
        .prod       (prod34),
        .prod_last  (prod_last34),
        .acc_valid  (acc_valid34),
        .acc_ready  (acc_ready34),
        .acc        (acc34),
        .acc_cnt    (acc_cnt34),
        .acc_ovf    (acc_ovf34)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one term and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] p, input logic last);
        bit done = 0;
        prod_valid = 1'b1;
        prod       = p;
        prod_last  = last;
        for (int i = 0; i < 20 && !done; i++) begin
            if (prod_ready) done = 1;
            step();
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    int signed   neg_a;
    logic [31:0] p_neg;
    logic [39:0] e2e_sum;

    initial begin
        rst          = 1'b1;
        prod_valid   = 1'b0;
        prod         = '0;
        prod_last    = 1'b0;
        acc_ready    = 1'b0;
        prod_valid34 = 1'b0;
        prod34       = '0;
        prod_last34  = 1'b0;
        acc_ready34  = 1'b0;
        step();
        step();

        // Reset state
        check("rst_prod_ready", 64'(prod_ready), 64'd0);
        check("rst_acc_valid",  64'(acc_valid),  64'd0);
        check("rst_acc",        64'(acc),        64'd0);
        check("rst_cnt",        64'(acc_cnt),    64'd0);
        check("rst_ovf",        64'(acc_ovf),    64'd0);
        rst = 1'b0;
        #1;
        check("idle_prod_ready", 64'(prod_ready), 64'd1);

        // Single-term packet
        send(32'h3FFF0001, 1'b1);
        check("t1_valid", 64'(acc_valid),  64'd1);
        check("t1_acc",   64'(acc),        64'h003FFF0001);
        check("t1_cnt",   64'(acc_cnt),    64'd1);
        check("t1_ovf",   64'(acc_ovf),    64'd0);
        check("t1_ready", 64'(prod_ready), 64'd0);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        check("t1_valid_drop", 64'(acc_valid),  64'd0);
        check("t1_ready_back", 64'(prod_ready), 64'd1);
        check("t1_acc_hold",   64'(acc),        64'h003FFF0001);

        // Three terms 100, -50, 7 -> 57
        acc_ready = 1'b1;
        send(32'd100, 1'b0);
        send(-32'sd50, 1'b0);
        send(32'd7, 1'b1);
        check("t2_valid", 64'(acc_valid), 64'd1);
        check("t2_acc",   64'(acc),       64'd57);
        check("t2_cnt",   64'(acc_cnt),   64'd3);
        step();
        acc_ready = 1'b0;
        check("t2_valid_1cyc", 64'(acc_valid),  64'd0);
        check("t2_ready",      64'(prod_ready), 64'd1);

        // Backpressure: result held 5 cycles while the next term waits
        send(32'd11, 1'b0);
        send(32'd22, 1'b1);
        prod_valid = 1'b1;
        prod       = 32'd44;
        prod_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t3_ready_low", 64'(prod_ready), 64'd0);
            check("t3_acc_hold",  64'(acc),        64'd33);
            check("t3_valid",     64'(acc_valid),  64'd1);
            step();
        end
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        check("t3_held_ready", 64'(prod_ready), 64'd1);
        step();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        check("t3_next_valid", 64'(acc_valid), 64'd1);
        check("t3_next_acc",   64'(acc),       64'd44);
        check("t3_next_cnt",   64'(acc_cnt),   64'd1);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;

        // Reset mid-packet discards it
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_valid_after_rst", 64'(acc_valid), 64'd0);
        check("t5_acc_after_rst",   64'(acc),       64'd0);
        step();
        check("t5_valid_later",     64'(acc_valid), 64'd0);
        send(32'd5, 1'b1);
        check("t5_valid", 64'(acc_valid), 64'd1);
        check("t5_acc",   64'(acc),       64'd5);
        check("t5_cnt",   64'(acc_cnt),   64'd1);
        check("t5_ovf",   64'(acc_ovf),   64'd0);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;

        // Two products as produced for 7FFF*7FFF and 8001*8001
        neg_a   = -32767;
        p_neg   = 32'(neg_a * neg_a);
        e2e_sum = 40'd2147352578;
        send(32'h3FFF0001, 1'b0);
        send(p_neg, 1'b1);
        check("t6_acc", 64'(acc),     64'(e2e_sum));
        check("t6_cnt", 64'(acc_cnt), 64'd2);
        check("t6_ovf", 64'(acc_ovf), 64'd0);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;

        // 34-bit accumulator, nine terms of 3FFF0001: overflow on the ninth
        prod34       = 32'h3FFF0001;
        prod_valid34 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            prod_last34 = (i == 8);
            check("t4_ready", 64'(prod_ready34), 64'd1);
            step();
            if (i == 7) check("t4_no_ovf_8", 64'(acc_ovf34), 64'd0);
        end
        prod_valid34 = 1'b0;
        prod_last34  = 1'b0;
        check("t4_valid", 64'(acc_valid34), 64'd1);
        check("t4_ovf",   64'(acc_ovf34),   64'd1);
        check("t4_cnt_sat", 64'(acc_cnt34), 64'd7);
`ifdef SATURATE_EN
        check("t4_acc_sat",  64'(acc34), 64'h1FFFFFFFF);   // +2^33-1
`else
        check("t4_acc_wrap", 64'(acc34), 64'h23FF70009);   // -7516782583 in 34 bits
`endif
        acc_ready34 = 1'b1;
        step();
        acc_ready34 = 1'b0;
        check("t4_idle", 64'(acc_valid34), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
